// File: rtl/dw2_gen.sv
// Output-layer delta-weight generator: accumulates delta2*h_act over a batch, then scales,
// negates and saturates the sum into a one-cycle weight update request.
module dw2_gen #(
  parameter int unsigned ETA_SHIFT  = 2,
  parameter int unsigned BATCH_LOG2 = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               init_i,
  input  logic               sample_valid_i,
  output logic               sample_ready_o,
  input  logic signed [15:0] delta2_i,
  input  logic signed [15:0] h_act_i,
  output logic signed [15:0] dw2_o,
  output logic               select_initial_o,
  output logic               select_update_o
);

  localparam int unsigned AccW  = 32 + BATCH_LOG2;
  localparam int unsigned NegW  = AccW + 1;
  localparam int unsigned CntW  = BATCH_LOG2 + 1;
  localparam int unsigned Shift = 10 + ETA_SHIFT + BATCH_LOG2;

  localparam logic [CntW-1:0]        BatchSize = CntW'(1) << BATCH_LOG2;
  localparam logic signed [NegW-1:0] SatMax    = NegW'(32767);
  localparam logic signed [NegW-1:0] SatMin    = NegW'(-32768);

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StMul,
    StScale,
    StUpdate,
    StInit
  } state_e;

  state_e                   state_q, state_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic        [CntW-1:0]   cnt_q, cnt_d;
  logic signed [15:0]       op_a_q, op_a_d;
  logic signed [15:0]       op_b_q, op_b_d;
  logic                     ready_q, ready_d;
  logic                     sel_init_q, sel_init_d;
  logic                     sel_upd_q, sel_upd_d;
  logic signed [15:0]       dw2_q, dw2_d;

  logic                     accept;
  logic signed [31:0]       prod;
  logic signed [AccW-1:0]   prod_ext;
  logic signed [AccW-1:0]   acc_sh;
  logic signed [NegW-1:0]   acc_neg;
  logic signed [15:0]       sat_val;

  assign accept   = sample_valid_i & ready_q;
  assign prod     = 32'(op_a_q) * 32'(op_b_q);
  assign prod_ext = AccW'(prod);

  // Shift before negating so truncation is toward -inf of the positive-gradient sum.
  assign acc_sh  = acc_q >>> Shift;
  assign acc_neg = -NegW'(acc_sh);

  always_comb begin
    if (acc_neg > SatMax) begin
      sat_val = 16'sh7FFF;
    end else if (acc_neg < SatMin) begin
      sat_val = 16'sh8000;
    end else begin
      sat_val = acc_neg[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;

    // init wins over everything, including a sample offered in the same cycle.
    if (init_i) begin
      state_d = StInit;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            op_a_d  = delta2_i;
            op_b_d  = h_act_i;
            state_d = StMul;
          end
        end
        StMul: begin
          acc_d   = acc_q + prod_ext;
          cnt_d   = cnt_q + CntW'(1);
          state_d = (cnt_d == BatchSize) ? StScale : StAccum;
        end
        StScale: begin
          state_d = StUpdate;
        end
        StUpdate: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
        StInit: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    ready_d    = (state_d == StIdle) || (state_d == StAccum);
    sel_init_d = (state_d == StInit);
    sel_upd_d  = (state_d == StUpdate);
    // StUpdate is only reachable from StScale, where acc_q holds the finished batch sum.
    dw2_d      = sel_upd_d ? sat_val : 16'sh0000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      ready_q    <= 1'b0;
      sel_init_q <= 1'b0;
      sel_upd_q  <= 1'b0;
      dw2_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      ready_q    <= ready_d;
      sel_init_q <= sel_init_d;
      sel_upd_q  <= sel_upd_d;
      dw2_q      <= dw2_d;
    end
  end

  assign sample_ready_o   = ready_q;
  assign select_initial_o = sel_init_q;
  assign select_update_o  = sel_upd_q;
  assign dw2_o            = dw2_q;

  a_sel_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(select_initial_o && select_update_o));

  a_dw2_only_in_update: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dw2_o != 16'sh0000) |-> select_update_o);

endmodule

// File: doc/dw2_gen.md
DW2_GEN -- requirements
Module: dw2_gen

Interface
REQ-001 Parameter ETA_SHIFT, default 2: learning rate = 2^-ETA_SHIFT.
REQ-002 Parameter BATCH_LOG2, default 2: samples per weight update = 2^BATCH_LOG2.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 init  input  1  request to load initial weight, high active.
REQ-006 sample_valid  input  1  delta2/h_act valid, high active.
REQ-007 sample_ready  output  1  block accepts a sample this cycle.
REQ-008 delta2  input  16  signed Q6.10 output-layer error term.
REQ-009 h_act  input  16  signed Q6.10 hidden-layer activation.
REQ-010 dw2  output  16  signed Q6.10 delta weight, drives the weight register's delta input.
REQ-011 select_initial  output  1  one-cycle pulse: weight register loads its initial value.
REQ-012 select_update  output  1  one-cycle pulse: weight register adds dw2.

Function
REQ-013 States IDLE, ACCUM, MUL, SCALE, UPDATE, INIT. Outputs decode from state and registers; no combinational input-to-output path.
REQ-014 sample_ready = 1 in IDLE and ACCUM only, else 0.
REQ-015 Accept when sample_valid & sample_ready at an edge: operands registered, next state MUL.
REQ-016 MUL, one cycle: acc += delta2*h_act (32-bit signed Q12.20 product, sign-extended into a (32+BATCH_LOG2)-bit signed accumulator); count += 1. Next state SCALE if count reaches 2^BATCH_LOG2, else ACCUM.
REQ-017 Sustained sample_valid gives one accept per 2 cycles; sample_valid with ready low is neither accepted nor lost (source holds it).
REQ-018 SCALE, one cycle: dw2 register <= saturate16( -(acc >>> (10+ETA_SHIFT+BATCH_LOG2)) ). Arithmetic shift truncates toward -inf; negation applies after the shift; saturation limits are 0x7FFF / 0x8000. Next state UPDATE.
REQ-019 UPDATE, one cycle: select_update = 1 and dw2 = computed value. At exit, acc and count clear, next state IDLE.
REQ-020 dw2 = 0 in every state except UPDATE.
REQ-021 init sampled high in any state at an edge: next state INIT; acc and count clear; any batch in progress is discarded; no select_update for it.
REQ-022 INIT, one cycle: select_initial = 1, select_update = 0. Next state IDLE. init held high re-enters INIT each cycle, so select_initial stays high.
REQ-023 init has priority over a simultaneous sample accept; that sample is dropped.
REQ-024 select_initial and select_update are never high in the same cycle.

Reset
REQ-025 reset low forces, immediately and independent of clk: state IDLE, acc 0, count 0, operand registers 0, dw2 0, select_initial 0, select_update 0.
REQ-026 sample_ready = 1 from the first cycle after reset deasserts.
REQ-027 reset asserted mid-batch discards all partial accumulation; no update pulse follows release.

Verification (defaults ETA_SHIFT=2, BATCH_LOG2=2)
REQ-028 Assert reset mid-MUL, then release. Required: all outputs 0 at once; sample_ready = 1 after release.
REQ-029 One-cycle init pulse from IDLE. Required: select_initial high exactly the next cycle; dw2 = 0; sample_ready low in that cycle.
REQ-030 4 samples, each delta2 = 0x0400 and h_act = 0x0200, sample_valid held high. Required:
  - accepts on every other cycle;
  - SCALE follows, then UPDATE;
  - in UPDATE, dw2 = 0xFF80 (-0.125) with select_update high for exactly one cycle.
REQ-031 Saturation, 4 samples each:
  - delta2 = h_act = 0x7FFF: dw2 = 0x8000;
  - delta2 = 0x8000, h_act = 0x7FFF: dw2 = 0x7FFF.
REQ-032 init after 2 accepted samples. Required: select_initial pulse and no select_update. The next 4 samples of REQ-030 yield dw2 = 0xFF80, so no residue remains.
REQ-033 init and sample_valid asserted in the same IDLE cycle. Required: INIT is entered; the sample is not counted; 4 further samples are needed before the next UPDATE.
